// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects plus a load-use stall sequencer and a
// saturating stall-cycle counter for performance monitoring.
//
// state | meaning
// IDLE  | no stall in progress; a load-use detect stalls this cycle
// STALL | extra stall cycles of a multi-cycle load-use hazard
module fwd_hazard_unit #(
   parameter int ADDR_W      = 3,
   parameter int NUM_SRC     = 2,
   parameter int LOAD_LAT    = 1,
   parameter int ZERO_REG_EN = 1,
   parameter int CNT_W       = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
   input  logic [NUM_SRC-1:0]        id_src_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr_i,
   input  logic [ADDR_W-1:0]         ex_write_addr_i,
   input  logic                      ex_regwrite_i,
   input  logic                      ex_memread_i,
   input  logic [ADDR_W-1:0]         mem_write_addr_i,
   input  logic                      mem_regwrite_i,
   input  logic                      mem_memread_i,
   input  logic [ADDR_W-1:0]         wb_write_addr_i,
   input  logic                      wb_regwrite_i,
   input  logic                      wb_memread_i,
   input  logic                      flush_i,
   output logic [NUM_SRC*2-1:0]      fwd_sel_o,
   output logic                      stall_o,
   output logic                      bubble_o,
   output logic [CNT_W-1:0]          stall_count_o
);

   typedef enum logic {IDLE, STALL} state_t;

   state_t     state, state_nxt;
   logic [1:0] remaining, remaining_nxt;
   logic       detect;

   function automatic logic excluded(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG_EN != 0) && (addr == '0);
   endfunction

   // A load sitting in EX/MEM has no data yet, so it yields to MEM/WB.
   function automatic logic [1:0] fwd_pick(input logic [ADDR_W-1:0] src);
      logic mem_hit, wb_hit;
      mem_hit = mem_regwrite_i && (mem_write_addr_i == src) && !excluded(src);
      wb_hit  = wb_regwrite_i && (wb_write_addr_i == src) && !excluded(src);
      if (mem_hit && !mem_memread_i) return 2'd3;
      if (wb_hit) return wb_memread_i ? 2'd2 : 2'd1;
      return 2'd0;
   endfunction

   always_comb begin
      fwd_sel_o = '0;
      if (!rst_i) begin
         for (int k = 0; k < NUM_SRC; k++)
            fwd_sel_o[k*2 +: 2] = fwd_pick(ex_src_addr_i[k*ADDR_W +: ADDR_W]);
      end
   end

   always_comb begin
      detect = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (id_src_valid_i[k] && (id_src_addr_i[k*ADDR_W +: ADDR_W] == ex_write_addr_i)
             && !excluded(ex_write_addr_i))
            detect = 1'b1;
      end
      detect = detect && ex_memread_i && ex_regwrite_i;
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      stall_o       = 1'b0;
      if (rst_i || flush_i) begin
         state_nxt     = IDLE;
         remaining_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (detect) begin
                  stall_o = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_nxt     = STALL;
                     remaining_nxt = 2'(LOAD_LAT - 1);
                  end
               end
            end
            STALL: begin
               stall_o       = 1'b1;
               remaining_nxt = remaining - 2'd1;
               if (remaining == 2'd1) state_nxt = IDLE;
            end
            default: begin
               state_nxt     = IDLE;
               remaining_nxt = '0;
            end
         endcase
      end
   end

   assign bubble_o = stall_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         remaining     <= '0;
         stall_count_o <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         if (stall_o && (stall_count_o != {CNT_W{1'b1}}))
            stall_count_o <= stall_count_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three parameterisations share one stimulus stream
// and are compared each cycle against a cycle-level behavioural model.
module tb_fwd_hazard_unit;

   localparam int LAT  [3] = '{1, 3, 2};
   localparam int ZEN  [3] = '{1, 0, 1};
   localparam int CMAX [3] = '{65535, 15, 65535};

   logic       clk = 1'b0;
   logic       rst, flush;
   logic [2:0] id_src [2];
   logic [2:0] ex_src [2];
   logic [1:0] id_valid;
   logic [2:0] ex_wa, mem_wa, wb_wa;
   logic       ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, wb_mr;
   logic [5:0] id_bus, ex_bus;

   logic [3:0]  fsel0, fsel1, fsel2;
   logic        stall0, stall1, stall2, bub0, bub1, bub2;
   logic [15:0] cnt0, cnt2;
   logic [3:0]  cnt1;

   int checks = 0;
   int errors = 0;
   int pend [3];
   int cnt  [3];

   assign id_bus = {id_src[1], id_src[0]};
   assign ex_bus = {ex_src[1], ex_src[0]};

   always #5 clk = ~clk;

   fwd_hazard_unit #(.ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_EN(1), .CNT_W(16)) u0 (
      .clk_i(clk), .rst_i(rst), .id_src_addr_i(id_bus), .id_src_valid_i(id_valid),
      .ex_src_addr_i(ex_bus), .ex_write_addr_i(ex_wa), .ex_regwrite_i(ex_rw),
      .ex_memread_i(ex_mr), .mem_write_addr_i(mem_wa), .mem_regwrite_i(mem_rw),
      .mem_memread_i(mem_mr), .wb_write_addr_i(wb_wa), .wb_regwrite_i(wb_rw),
      .wb_memread_i(wb_mr), .flush_i(flush), .fwd_sel_o(fsel0), .stall_o(stall0),
      .bubble_o(bub0), .stall_count_o(cnt0));

   fwd_hazard_unit #(.ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_EN(0), .CNT_W(4)) u1 (
      .clk_i(clk), .rst_i(rst), .id_src_addr_i(id_bus), .id_src_valid_i(id_valid),
      .ex_src_addr_i(ex_bus), .ex_write_addr_i(ex_wa), .ex_regwrite_i(ex_rw),
      .ex_memread_i(ex_mr), .mem_write_addr_i(mem_wa), .mem_regwrite_i(mem_rw),
      .mem_memread_i(mem_mr), .wb_write_addr_i(wb_wa), .wb_regwrite_i(wb_rw),
      .wb_memread_i(wb_mr), .flush_i(flush), .fwd_sel_o(fsel1), .stall_o(stall1),
      .bubble_o(bub1), .stall_count_o(cnt1));

   fwd_hazard_unit #(.ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(2), .ZERO_REG_EN(1), .CNT_W(16)) u2 (
      .clk_i(clk), .rst_i(rst), .id_src_addr_i(id_bus), .id_src_valid_i(id_valid),
      .ex_src_addr_i(ex_bus), .ex_write_addr_i(ex_wa), .ex_regwrite_i(ex_rw),
      .ex_memread_i(ex_mr), .mem_write_addr_i(mem_wa), .mem_regwrite_i(mem_rw),
      .mem_memread_i(mem_mr), .wb_write_addr_i(wb_wa), .wb_regwrite_i(wb_rw),
      .wb_memread_i(wb_mr), .flush_i(flush), .fwd_sel_o(fsel2), .stall_o(stall2),
      .bubble_o(bub2), .stall_count_o(cnt2));

   function automatic logic [31:0] obs_fsel(int i);
      case (i)
         0: return 32'(fsel0);
         1: return 32'(fsel1);
         default: return 32'(fsel2);
      endcase
   endfunction

   function automatic logic [31:0] obs_stall(int i);
      case (i)
         0: return 32'(stall0);
         1: return 32'(stall1);
         default: return 32'(stall2);
      endcase
   endfunction

   function automatic logic [31:0] obs_bubble(int i);
      case (i)
         0: return 32'(bub0);
         1: return 32'(bub1);
         default: return 32'(bub2);
      endcase
   endfunction

   function automatic logic [31:0] obs_cnt(int i);
      case (i)
         0: return 32'(cnt0);
         1: return 32'(cnt1);
         default: return 32'(cnt2);
      endcase
   endfunction

   // Expected packed selects: each operand looks for the youngest ready producer.
   function automatic logic [31:0] ref_fwd(int zen);
      logic [31:0] r;
      int a, s;
      bit excl, mh, wh;
      r = 0;
      for (int k = 0; k < 2; k++) begin
         a    = int'(ex_src[k]);
         excl = (zen != 0) && (a == 0);
         mh   = mem_rw && (int'(mem_wa) == a) && !excl;
         wh   = wb_rw && (int'(wb_wa) == a) && !excl;
         if (mh && !mem_mr) s = 3;
         else if (wh) s = wb_mr ? 2 : 1;
         else s = 0;
         r = r + 32'(s * (4 ** k));
      end
      if (rst) r = 0;
      return r;
   endfunction

   function automatic bit ref_detect(int zen);
      bit hit;
      hit = 0;
      for (int k = 0; k < 2; k++)
         if (id_valid[k] && (id_src[k] == ex_wa) && !((zen != 0) && (ex_wa == 0))) hit = 1;
      return hit && ex_mr && ex_rw;
   endfunction

   function automatic bit ref_stall(int i);
      if (rst || flush) return 0;
      if (pend[i] > 0) return 1;
      return ref_detect(ZEN[i]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit st;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("fwd_sel_u%0d", i), obs_fsel(i), ref_fwd(ZEN[i]));
         chk($sformatf("stall_u%0d", i), obs_stall(i), 32'(ref_stall(i)));
         chk($sformatf("bubble_u%0d", i), obs_bubble(i), 32'(ref_stall(i)));
         chk($sformatf("count_u%0d", i), obs_cnt(i), 32'(cnt[i]));
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         st = ref_stall(i);
         if (rst) begin
            pend[i] = 0;
            cnt[i]  = 0;
         end else begin
            if (st && cnt[i] < CMAX[i]) cnt[i]++;
            if (flush) pend[i] = 0;
            else if (pend[i] > 0) pend[i]--;
            else if (ref_detect(ZEN[i])) pend[i] = LAT[i] - 1;
         end
      end
      #1;
   endtask

   task automatic clear();
      flush = 0; id_valid = 0; ex_wa = 0; mem_wa = 0; wb_wa = 0;
      ex_rw = 0; ex_mr = 0; mem_rw = 0; mem_mr = 0; wb_rw = 0; wb_mr = 0;
      for (int k = 0; k < 2; k++) begin
         id_src[k] = 0;
         ex_src[k] = 0;
      end
   endtask

   task automatic do_reset();
      clear();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   task automatic hazard_r3();
      ex_rw = 1; ex_mr = 1; ex_wa = 3'd3; id_src[0] = 3'd3; id_valid = 2'b01;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         pend[i] = 0;
         cnt[i]  = 0;
      end
      clear();
      rst = 1;
      cycle();
      #2;
      chk("rst_fwd", 32'(fsel0), 0);
      chk("rst_stall", 32'(stall1), 0);
      chk("rst_count", 32'(cnt1), 0);
      rst = 0;

      // forwarding priority
      mem_rw = 1; mem_wa = 3'd5; ex_src[0] = 3'd5; wb_rw = 1; wb_wa = 3'd5; ex_src[1] = 3'd6;
      #2;
      chk("t1_exmem_wins", 32'(fsel0[1:0]), 3);
      chk("t1_op1_regfile", 32'(fsel0[3:2]), 0);
      cycle();
      mem_rw = 0;
      #2;
      chk("t1_memwb_alu", 32'(fsel0[1:0]), 1);
      cycle();
      wb_mr = 1;
      #2;
      chk("t1_memwb_load", 32'(fsel0[1:0]), 2);
      cycle();
      mem_rw = 1; mem_mr = 1;
      #2;
      chk("t1_exmem_load_fallthru", 32'(fsel0[1:0]), 2);
      cycle();

      // register zero handling
      do_reset();
      mem_rw = 1; mem_wa = 0; wb_rw = 1; wb_wa = 0;
      ex_rw = 1; ex_mr = 1; ex_wa = 0; id_valid = 2'b01;
      #2;
      chk("t2_zen_fwd", 32'(fsel0), 0);
      chk("t2_zen_stall", 32'(stall0), 0);
      chk("t2_zen_stall_u2", 32'(stall2), 0);
      chk("t2_nozen_fwd", 32'(fsel1), 32'hF);
      chk("t2_nozen_stall", 32'(stall1), 1);
      cycle();
      clear();
      repeat (3) cycle();

      // single-cycle load-use stall
      do_reset();
      hazard_r3();
      #2;
      chk("t3_stall", 32'(stall0), 1);
      chk("t3_bubble", 32'(bub0), 1);
      chk("t3_cnt_before", 32'(cnt0), 0);
      cycle();
      clear();
      #2;
      chk("t3_stall_released", 32'(stall0), 0);
      chk("t3_cnt_after", 32'(cnt0), 1);
      cycle();
      hazard_r3();
      id_valid = 2'b00;
      #2;
      chk("t3_invalid_no_stall", 32'(stall0), 0);
      cycle();
      id_src[1] = 3'd3; id_valid = 2'b10;
      #2;
      chk("t3_op1_stall", 32'(stall0), 1);
      cycle();
      clear();
      repeat (3) cycle();

      // three-cycle stall ignores a detect raised mid-stall
      do_reset();
      hazard_r3();
      #2;
      chk("t4_n", 32'(stall1), 1);
      cycle();
      ex_wa = 3'd4; id_src[1] = 3'd4; id_valid = 2'b10;
      #2;
      chk("t4_n1", 32'(stall1), 1);
      cycle();
      clear();
      #2;
      chk("t4_n2", 32'(stall1), 1);
      cycle();
      #2;
      chk("t4_n3", 32'(stall1), 0);
      chk("t4_count", 32'(cnt1), 3);
      cycle();

      // flush and reset abort a stall
      do_reset();
      hazard_r3();
      cycle();
      clear();
      flush = 1;
      #2;
      chk("t5_flush_stall", 32'(stall1), 0);
      chk("t5_flush_bubble", 32'(bub1), 0);
      cycle();
      flush = 0;
      #2;
      chk("t5_after_flush", 32'(stall1), 0);
      chk("t5_flush_count", 32'(cnt1), 1);
      cycle();
      hazard_r3();
      #2;
      chk("t5_fresh_stall", 32'(stall1), 1);
      cycle();
      rst = 1; mem_rw = 1; mem_wa = 3'd3; ex_src[0] = 3'd3;
      #2;
      chk("t5_rst_stall", 32'(stall1), 0);
      chk("t5_rst_fwd", 32'(fsel1), 0);
      cycle();
      rst = 0;
      clear();
      #2;
      chk("t5_rst_count", 32'(cnt1), 0);
      chk("t5_rst_idle", 32'(stall1), 0);
      cycle();

      // counter saturation
      do_reset();
      hazard_r3();
      repeat (20) cycle();
      clear();
      #2;
      chk("t6_sat4", 32'(cnt1), 15);
      chk("t6_cnt16", 32'(cnt0), 20);
      chk("t6_cnt16_lat2", 32'(cnt2), 20);
      cycle();

      // randomized traffic
      repeat (400) begin
         rst      = ($urandom_range(0, 63) == 0);
         flush    = ($urandom_range(0, 11) == 0);
         id_valid = 2'($urandom_range(0, 3));
         ex_wa    = 3'($urandom_range(0, 3));
         mem_wa   = 3'($urandom_range(0, 3));
         wb_wa    = 3'($urandom_range(0, 3));
         ex_rw    = 1'($urandom_range(0, 1));
         ex_mr    = 1'($urandom_range(0, 1));
         mem_rw   = 1'($urandom_range(0, 1));
         mem_mr   = 1'($urandom_range(0, 1));
         wb_rw    = 1'($urandom_range(0, 1));
         wb_mr    = 1'($urandom_range(0, 1));
         for (int k = 0; k < 2; k++) begin
            id_src[k] = 3'($urandom_range(0, 3));
            ex_src[k] = 3'($urandom_range(0, 3));
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
